inst_mem_loader: RTL and testbench

- Writer side of the instruction-memory interface; the datapath's fetch path is the reader.
- Accepts a byte stream (valid/ready) carrying a program image and assembles little-endian 32-bit words.
- Writes each word into instruction memory at byte address 4*i and verifies an XOR checksum.
- Holds the CPU (cpu_hold) until a complete, verified image is in memory.

---
 rtl/inst_mem_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Writer side of the instruction-memory interface. Receives a framed
//   program image as a byte stream, assembles little-endian 32-bit words,
//   writes them to word-aligned byte addresses and verifies an XOR checksum.
//   The CPU is held (cpu_hold=1) until a complete, verified image is loaded.
//
//   Frame: N (4 bytes, LE, in words), 4*N payload bytes (LSB first per word),
//          1 checksum byte = XOR of all payload bytes.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   start       begin a load (honoured only in IDLE, DONE, ERROR)
//   byte_valid  byte_data carries a byte this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we      one-cycle instruction-memory write strobe
//   mem_addr    word-aligned byte address of the write
//   mem_wdata   assembled instruction word
//   cpu_hold    keep the CPU in reset; low only when the image is verified
//   done        image loaded and checksum matched
//   err         length overflow or checksum mismatch
//   word_count  words written so far in the current load
module inst_mem_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  // Running XOR checksum step.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       byte_cnt_r;
  logic [31:0]      len_r;
  logic [23:0]      word_r;
  logic [7:0]       csum_r;
  logic [CNT_W-1:0] word_count_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             byte_ready_r;
  logic             mem_we_r;
  logic             cpu_hold_r;
  logic             done_r;
  logic             err_r;

  logic             xfer_s;
  logic             last_byte_s;
  logic             start_ok_s;
  logic [31:0]      len_full_s;
  logic [31:0]      next_count_s;
  logic             byte_ready_s;
  logic             mem_we_s;
  logic             cpu_hold_s;
  logic             done_s;
  logic             err_s;

  assign xfer_s       = byte_valid & byte_ready_r;
  assign last_byte_s  = (byte_cnt_r == 2'd3);
  assign start_ok_s   = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
  // Length as it stands once the 4th (most significant) length byte arrives.
  assign len_full_s   = {byte_data, len_r[23:0]};
  assign next_count_s = 32'(word_count_r) + 32'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          next_state_s = S_LEN;
        end else begin
          next_state_s = state_r;
        end
      end
      S_LEN: begin
        if (xfer_s && last_byte_s) begin
          if (len_full_s > MAX_LEN) begin
            next_state_s = S_ERROR;
          end else if (len_full_s == 32'd0) begin
            next_state_s = S_CHECK;
          end else begin
            next_state_s = S_DATA;
          end
        end else begin
          next_state_s = S_LEN;
        end
      end
      S_DATA: begin
        if (xfer_s && last_byte_s) begin
          next_state_s = S_WRITE;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_WRITE: begin
        if (next_count_s == len_r) begin
          next_state_s = S_CHECK;
        end else begin
          next_state_s = S_DATA;
        end
      end
      S_CHECK: begin
        if (xfer_s) begin
          if (byte_data == csum_r) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_ERROR;
          end
        end else begin
          next_state_s = S_CHECK;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    byte_ready_s = 1'b0;
    mem_we_s     = 1'b0;
    cpu_hold_s   = 1'b1;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (next_state_s)
      S_LEN, S_DATA, S_CHECK: byte_ready_s = 1'b1;
      S_WRITE:                mem_we_s     = 1'b1;
      S_DONE: begin
        done_s     = 1'b1;
        cpu_hold_s = 1'b0;
      end
      S_ERROR:                err_s        = 1'b1;
      default:                byte_ready_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      byte_ready_r <= byte_ready_s;
      mem_we_r     <= mem_we_s;
      cpu_hold_r   <= cpu_hold_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  // Datapath: length capture, word assembly, checksum and word counter.
  // The write address/data are latched with the 4th byte of each word and
  // then held until the next word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_r   <= 2'd0;
      len_r        <= 32'd0;
      word_r       <= 24'd0;
      csum_r       <= 8'd0;
      word_count_r <= {CNT_W{1'b0}};
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
    end else if (start_ok_s) begin
      byte_cnt_r   <= 2'd0;
      len_r        <= 32'd0;
      csum_r       <= 8'd0;
      word_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_LEN: begin
          if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0:    len_r[7:0]   <= byte_data;
              2'd1:    len_r[15:8]  <= byte_data;
              2'd2:    len_r[23:16] <= byte_data;
              default: len_r[31:24] <= byte_data;
            endcase
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            csum_r     <= csum_next(csum_r, byte_data);
            case (byte_cnt_r)
              2'd0:    word_r[7:0]   <= byte_data;
              2'd1:    word_r[15:8]  <= byte_data;
              2'd2:    word_r[23:16] <= byte_data;
              default: begin
                mem_wdata_r <= {byte_data, word_r};
                mem_addr_r  <= {{(30-CNT_W){1'b0}}, word_count_r, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: word_count_r <= word_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        default: byte_cnt_r <= byte_cnt_r;
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Testbench for inst_mem_loader: a default instance (MAX_WORDS=1024) and a
// small instance (MAX_WORDS=4) driven by directed and randomized frames.
// Expected writes and outcomes come from a frame-level model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        start_m, valid_m;
  logic [7:0]  data_m;
  logic        ready_m, we_m, hold_m, done_m, err_m;
  logic [31:0] addr_m, wdata_m;
  logic [10:0] wc_m;

  logic        start_x, valid_x;
  logic [7:0]  data_x;
  logic        ready_x, we_x, hold_x, done_x, err_x;
  logic [31:0] addr_x, wdata_x;
  logic [2:0]  wc_x;

  inst_mem_loader u_main (
    .clk(clk), .reset(reset), .start(start_m), .byte_valid(valid_m), .byte_data(data_m),
    .byte_ready(ready_m), .mem_we(we_m), .mem_addr(addr_m), .mem_wdata(wdata_m),
    .cpu_hold(hold_m), .done(done_m), .err(err_m), .word_count(wc_m)
  );

  inst_mem_loader #(.MAX_WORDS(4), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .start(start_x), .byte_valid(valid_x), .byte_data(data_x),
    .byte_ready(ready_x), .mem_we(we_x), .mem_addr(addr_x), .mem_wdata(wdata_x),
    .cpu_hold(hold_x), .done(done_x), .err(err_x), .word_count(wc_x)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t obs_m[$];
  wr_t obs_x[$];

  always @(posedge clk) cycle++;

  // Record every write strobe seen by memory.
  always @(negedge clk) begin
    if (we_m === 1'b1) obs_m.push_back('{addr_m, wdata_m, cycle});
    if (we_x === 1'b1) obs_x.push_back('{addr_x, wdata_x, cycle});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sm, input logic st, input logic v, input logic [7:0] d);
    if (sm) begin
      start_x = st; valid_x = v; data_x = d;
    end else begin
      start_m = st; valid_m = v; data_m = d;
    end
  endtask

  task automatic check_status(input bit sm, input string tag, input logic rdy, input logic dn,
                              input logic er, input logic hd, input logic [31:0] wc);
    check({tag, ".byte_ready"}, 32'(sm ? ready_x : ready_m), 32'(rdy));
    check({tag, ".done"},       32'(sm ? done_x  : done_m),  32'(dn));
    check({tag, ".err"},        32'(sm ? err_x   : err_m),   32'(er));
    check({tag, ".cpu_hold"},   32'(sm ? hold_x  : hold_m),  32'(hd));
    check({tag, ".word_count"}, sm ? 32'(wc_x) : 32'(wc_m),  wc);
  endtask

  // Offer one byte (optionally after a random idle gap) and wait until it
  // is transferred; junk data is shown while valid is low.
  task automatic send_byte(input bit sm, input logic [7:0] b, input bit gaps);
    int g;
    int n;
    g = 0;
    if (gaps && ($urandom_range(0, 2) == 0)) g = $urandom_range(1, 4);
    repeat (g) begin
      drive(sm, 1'b0, 1'b0, 8'($urandom));
      @(negedge clk);
    end
    drive(sm, 1'b0, 1'b1, b);
    n = 0;
    while (((sm ? ready_x : ready_m) !== 1'b1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL accept_timeout: waited=%0d cycles limit=50", n);
    end
    if (n < 50) begin
      @(posedge clk);
      @(negedge clk);
    end
    drive(sm, 1'b0, 1'b0, 8'h00);
  endtask

  // Drive one complete frame and compare against the frame-level model.
  // csum_delta=0 sends the correct checksum; nonzero corrupts it.
  task automatic run_load(input bit sm, input string tag, input logic [31:0] words[$],
                          input logic [31:0] n_len, input logic [7:0] csum_delta, input bit gaps);
    logic [31:0] max_len;
    logic [7:0]  csum;
    wr_t         obs[$];
    bit          ok;
    max_len = sm ? 32'd4 : 32'd1024;
    csum = 8'h00;
    foreach (words[i]) csum = csum ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    if (sm) obs_x.delete(); else obs_m.delete();

    drive(sm, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    drive(sm, 1'b0, 1'b0, 8'h00);
    check_status(sm, {tag, ".started"}, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);

    for (int k = 0; k < 4; k++) send_byte(sm, n_len[8*k +: 8], gaps);

    if (n_len > max_len) begin
      check_status(sm, {tag, ".overflow"}, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      repeat (3) @(negedge clk);
      check({tag, ".overflow_writes"}, sm ? 32'(obs_x.size()) : 32'(obs_m.size()), 32'd0);
      return;
    end

    foreach (words[i])
      for (int k = 0; k < 4; k++) send_byte(sm, words[i][8*k +: 8], gaps);
    send_byte(sm, csum ^ csum_delta, gaps);
    repeat (2) @(negedge clk);

    if (sm) obs = obs_x; else obs = obs_m;
    check({tag, ".write_count"}, 32'(obs.size()), n_len);
    for (int i = 0; i < obs.size() && i < words.size(); i++) begin
      check($sformatf("%s.addr[%0d]", tag, i), obs[i].addr, 32'(4 * i));
      check($sformatf("%s.data[%0d]", tag, i), obs[i].data, words[i]);
    end
    if (!gaps && obs.size() >= 2)
      check({tag, ".cycles_per_word"}, 32'(obs[1].cyc - obs[0].cyc), 32'd5);
    ok = (csum_delta == 8'h00);
    check_status(sm, {tag, ".end"}, 1'b0, ok, !ok, !ok, n_len);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] empty_q[$];
    int          n;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_status(1'b0, "reset_m", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("reset_m.mem_we", 32'(we_m), 32'd0);
    check("reset_m.mem_addr", addr_m, 32'd0);
    check("reset_m.mem_wdata", wdata_m, 32'd0);
    check_status(1'b1, "reset_x", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_status(1'b0, "idle_m", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Basic two-word program; the XOR of its eight payload bytes is 0xB0.
    q = '{32'h00100513, 32'h00200593};
    run_load(1'b0, "basic", q, 32'd2, 8'h00, 1'b0);
    // Same payload with checksum byte 0x00.
    run_load(1'b0, "bad_csum", q, 32'd2, 8'hB0, 1'b0);
    // Zero-length image.
    run_load(1'b0, "zero_len", empty_q, 32'd0, 8'h00, 1'b0);
    // Oversized lengths.
    run_load(1'b0, "overflow_m", empty_q, 32'd1025, 8'h00, 1'b0);
    run_load(1'b0, "overflow_big", empty_q, 32'h0100_0000, 8'h00, 1'b1);
    run_load(1'b1, "overflow_x", empty_q, 32'd5, 8'h00, 1'b0);
    // Exactly MAX_WORDS on the small instance, with stalls.
    q = '{};
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    run_load(1'b1, "max_x", q, 32'd4, 8'h00, 1'b1);

    // Randomized frames with gaps, some with corrupted checksums.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      q = '{};
      for (int i = 0; i < n; i++) q.push_back($urandom);
      run_load(1'b0, $sformatf("rand%0d", t), q, 32'(n),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b1);
    end

    // Reset after the 6th payload byte of a two-word load.
    obs_m.delete();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) send_byte(1'b0, (k == 0) ? 8'h02 : 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(1'b0, 8'(8'h40 + k), 1'b0);
    check("midreset.writes_before", 32'(obs_m.size()), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_status(1'b0, "midreset", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("midreset.mem_addr", addr_m, 32'd0);
    check("midreset.mem_wdata", wdata_m, 32'd0);
    obs_m.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset.no_writes", 32'(obs_m.size()), 32'd0);
    check("midreset.mem_we", 32'(we_m), 32'd0);
    q = '{32'hDEAD_BEEF};
    run_load(1'b0, "after_reset", q, 32'd1, 8'h00, 1'b0);

    // Full-size image on the default instance.
    q = '{};
    for (int i = 0; i < 1024; i++) q.push_back($urandom);
    run_load(1'b0, "max_m", q, 32'd1024, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
